instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 191 +++++++++++++++++++
 tb/tb_instruction_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Instruction fetch unit. Accepts fetch addresses from the PC,
//               issues at most one outstanding read to instruction memory and
//               buffers returned words (or fault entries) in a small FIFO that
//               feeds decode. Supports branch-redirect flush with discard of
//               any in-flight response.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               pc_in/pc_valid/pc_ready        - fetch address handshake
//               imem_req/imem_addr             - memory read request
//               imem_rvalid/imem_rdata         - memory read response
//               instr_valid/instr_ready        - decode handshake
//               instr_out/instr_pc/instr_fault - queue head contents
//               flush              - discard queued and in-flight fetches
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int QDEPTH     = 2,
  parameter int IMEM_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [63:0] instr_pc,
  output logic        instr_fault,
  input  logic        flush
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  localparam logic [CW:0]   c_qdepth     = (CW + 1)'(QDEPTH);
  localparam logic [PW-1:0] c_last_ptr   = PW'(QDEPTH - 1);
  localparam logic [63:0]   c_imem_limit = 64'(IMEM_BYTES);
  localparam logic [31:0]   c_nop        = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    DRAIN    = 2'd2
  } state_e;

  // Control state
  state_e        state_q,  state_d;
  logic [CW-1:0] count_q,  count_d;
  logic [PW-1:0] wptr_q,   wptr_d;
  logic [PW-1:0] rptr_q,   rptr_d;
  logic          pending_q, pending_d;
  logic [63:0]   req_pc_q, req_pc_d;

  // Queue storage (contents are only observed when count_q != 0)
  logic [63:0] pc_mem_q  [QDEPTH];
  logic [31:0] ins_mem_q [QDEPTH];
  logic        flt_mem_q [QDEPTH];

  logic [CW:0] used;
  logic        accept;
  logic        addr_ok;
  logic        rsp_take;
  logic        enq;
  logic        deq;
  logic [63:0] enq_pc;
  logic [31:0] enq_ins;
  logic        enq_flt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // Handshake and enqueue decode
  always_comb begin
    // The outstanding request already owns a slot, so a response can always land.
    used      = {1'b0, count_q} + (CW + 1)'(pending_q);
    pc_ready  = (state_q == IDLE) && (used < c_qdepth) && !flush && !reset;
    accept    = pc_valid && pc_ready;
    addr_ok   = (pc_in[1:0] == 2'b00) && (pc_in < c_imem_limit);
    imem_req  = accept && addr_ok;
    imem_addr = pc_in;

    // A response arriving with flush is dropped.
    rsp_take  = (state_q == WAIT_RSP) && imem_rvalid && !flush;
    enq       = (accept && !addr_ok) || rsp_take;
    enq_pc    = rsp_take ? req_pc_q   : pc_in;
    enq_ins   = rsp_take ? imem_rdata : c_nop;
    enq_flt   = !rsp_take;
    deq       = instr_ready && (count_q != '0);
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    req_pc_d  = req_pc_q;
    count_d   = count_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;

    case (state_q)
      IDLE: begin
        if (imem_req) begin
          state_d   = WAIT_RSP;
          pending_d = 1'b1;
          req_pc_d  = pc_in;
        end
      end
      WAIT_RSP: begin
        if (imem_rvalid) begin
          state_d   = IDLE;
          pending_d = 1'b0;
        end else if (flush) begin
          // Response still owed by memory; swallow it before fetching again.
          state_d   = DRAIN;
          pending_d = 1'b0;
        end
      end
      DRAIN: begin
        if (imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 1'b0;
      end
    endcase

    if (flush) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (enq) begin
        wptr_d = ptr_inc(wptr_q);
      end
      if (deq) begin
        rptr_d = ptr_inc(rptr_q);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      req_pc_q  <= '0;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_pc_q  <= req_pc_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && enq) begin
      pc_mem_q[wptr_q]  <= enq_pc;
      ins_mem_q[wptr_q] <= enq_ins;
      flt_mem_q[wptr_q] <= enq_flt;
    end
  end

  // Head outputs are forced to zero when the queue is empty.
  always_comb begin
    instr_valid = (count_q != '0);
    instr_out   = instr_valid ? ins_mem_q[rptr_q] : '0;
    instr_pc    = instr_valid ? pc_mem_q[rptr_q]  : '0;
    instr_fault = instr_valid ? flt_mem_q[rptr_q] : 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed testbench for instruction_fetch. Stimulus pushes the
//               expected queue entries into a scoreboard; a monitor pops and
//               compares whenever decode consumes the head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [63:0] instr_pc;
  logic        instr_fault;
  logic        flush;

  always #5 clk = ~clk;

  instruction_fetch #(
    .QDEPTH     (2),
    .IMEM_BYTES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_fault (instr_fault),
    .flush       (flush)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic quiet();
    pc_valid    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    flush       = 1'b0;
  endtask

  // Scoreboard monitor: every consumed head must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_instr: got pc %0h want none", instr_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("head_pc",    instr_pc,    mon_e.pc);
        chk("head_instr", instr_out,   mon_e.ins);
        chk("head_fault", instr_fault, mon_e.flt);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    pc_in       = '0;
    pc_valid    = 1'b1;
    instr_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    flush       = 1'b0;

    // ---- reset state ----
    smp();
    chk("rst_pc_ready",    pc_ready,    0);
    chk("rst_imem_req",    imem_req,    0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_pc",    instr_pc,    0);

    // ---- back-to-back fetches, latency 1 ----
    nxt(); reset = 1'b0; quiet(); pc_valid = 1'b1; pc_in = 64'd0; instr_ready = 1'b1;
    sb.push_back('{pc: 64'd0, ins: 32'h0050_0093, flt: 1'b0});
    smp();
    chk("a_pc_ready",  pc_ready,  1);
    chk("a_imem_req",  imem_req,  1);
    chk("a_imem_addr", imem_addr, 0);
    nxt(); quiet(); imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    smp();
    chk("a_valid_n1", instr_valid, 0);
    chk("a_ready_wait", pc_ready, 0);
    nxt(); quiet(); pc_valid = 1'b1; pc_in = 64'd4;
    sb.push_back('{pc: 64'd4, ins: 32'h0010_0113, flt: 1'b0});
    smp();
    chk("a_valid_n2", instr_valid, 1);
    chk("a_req2",     imem_req,    1);
    nxt(); quiet(); imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113;
    smp();
    chk("a_valid_gap", instr_valid, 0);
    nxt(); quiet();
    smp();
    chk("a_valid2", instr_valid, 1);
    nxt();
    smp();
    chk("a_empty", instr_valid, 0);

    // ---- misaligned and out-of-range fetches ----
    nxt(); quiet(); pc_valid = 1'b1; pc_in = 64'd2;
    sb.push_back('{pc: 64'd2, ins: 32'h0000_0013, flt: 1'b1});
    smp();
    chk("b_ready", pc_ready, 1);
    chk("b_req",   imem_req, 0);
    nxt(); quiet();
    smp();
    chk("b_valid", instr_valid, 1);
    nxt(); quiet(); pc_valid = 1'b1; pc_in = 64'd16;
    sb.push_back('{pc: 64'd16, ins: 32'h0000_0013, flt: 1'b1});
    smp();
    chk("b_req16", imem_req, 0);
    nxt(); quiet();
    smp();
    chk("b_valid16", instr_valid, 1);

    // ---- queue full with decode stalled ----
    nxt(); quiet(); instr_ready = 1'b0; pc_valid = 1'b1; pc_in = 64'd8;
    sb.push_back('{pc: 64'd8, ins: 32'hAAAA_0001, flt: 1'b0});
    smp();
    chk("c_req1", imem_req, 1);
    nxt(); quiet(); imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001;
    nxt(); quiet(); pc_valid = 1'b1; pc_in = 64'd12;
    sb.push_back('{pc: 64'd12, ins: 32'hAAAA_0002, flt: 1'b0});
    smp();
    chk("c_req2", imem_req, 1);
    nxt(); quiet(); imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0002;
    nxt(); quiet(); pc_valid = 1'b1; pc_in = 64'd0;
    smp();
    chk("c_ready_full", pc_ready, 0);
    chk("c_req_full",   imem_req, 0);
    nxt(); quiet(); instr_ready = 1'b1;
    smp();
    chk("c_ready_deq", pc_ready, 0);
    nxt(); quiet(); instr_ready = 1'b0;
    smp();
    chk("c_ready_after", pc_ready,    1);
    chk("c_valid_left",  instr_valid, 1);
    nxt(); quiet(); instr_ready = 1'b1;
    nxt();
    smp();
    chk("c_empty", instr_valid, 0);

    // ---- flush during WAIT_RSP, late response ----
    nxt(); quiet(); pc_valid = 1'b1; pc_in = 64'd4;
    smp();
    chk("d_req", imem_req, 1);
    nxt(); quiet(); flush = 1'b1;
    smp();
    chk("d_ready_fl", pc_ready, 0);
    nxt(); quiet(); pc_valid = 1'b1; pc_in = 64'd0;
    smp();
    chk("d_ready_dr1", pc_ready, 0);
    chk("d_req_dr1",   imem_req, 0);
    nxt();
    smp();
    chk("d_ready_dr2", pc_ready, 0);
    nxt(); quiet(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    smp();
    chk("d_ready_rsp", pc_ready, 0);
    nxt(); quiet();
    smp();
    chk("d_ready_post", pc_ready,    1);
    chk("d_valid",      instr_valid, 0);

    // ---- flush with same-cycle response and pc_valid ----
    nxt(); quiet(); instr_ready = 1'b0; pc_valid = 1'b1; pc_in = 64'd2;
    nxt(); quiet(); pc_valid = 1'b1; pc_in = 64'd0;
    smp();
    chk("e_req", imem_req, 1);
    nxt(); quiet(); flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
    pc_valid = 1'b1; pc_in = 64'd4;
    smp();
    chk("e_ready", pc_ready, 0);
    chk("e_req_fl", imem_req, 0);
    nxt(); quiet();
    smp();
    chk("e_valid", instr_valid, 0);
    chk("e_idle",  pc_ready,    1);

    // ---- reset mid-request with one entry queued ----
    nxt(); quiet(); pc_valid = 1'b1; pc_in = 64'd2;
    nxt(); quiet(); pc_valid = 1'b1; pc_in = 64'd8;
    smp();
    chk("f_req", imem_req, 1);
    nxt(); quiet(); reset = 1'b1;
    smp();
    chk("f_ready_rst", pc_ready, 0);
    chk("f_req_rst",   imem_req, 0);
    nxt(); quiet(); reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    smp();
    chk("f_valid", instr_valid, 0);
    chk("f_out",   instr_out,   0);
    chk("f_pc",    instr_pc,    0);
    chk("f_fault", instr_fault, 0);
    chk("f_idle",  pc_ready,    1);
    nxt(); quiet(); instr_ready = 1'b1;
    smp();
    chk("f_valid_late", instr_valid, 0);
    nxt();
    smp();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
